uart_imem_loader: RTL and testbench
===================================

Name: uart_imem_loader

Overview:
- Sits in the user project between the serial programming pin (mprj_io[5]) and the core's instruction memory.
- Receives 8N1 UART bytes from the external programmer and packs them little-endian into 32-bit words. Each completed word is written to consecutive instruction-memory addresses.
- Holds the FPU core in reset until loading finishes, then releases it.
- Advertises readiness to the programmer on mprj_io[37].

Parameters:
- CLKS_PER_BIT, 347, wb_clk_i cycles per UART bit (40 MHz / 115200), must be >= 4
- ADDR_W, 8, instruction-memory word-address width
- END_WORD, 32'h0000_0FFF, terminator word; ends loading and is not written

Ports:
- wb_clk_i  in  1  system clock
- wb_rst_i  in  1  asynchronous, active-high reset
- rx_i  in  1  UART serial input, idle high, asynchronous to wb_clk_i
- ready_o  out  1  high while accepting program bytes; drives mprj_io[37]
- imem_we_o  out  1  one-cycle write strobe
- imem_addr_o  out  ADDR_W  word address of the current write
- imem_wdata_o  out  32  word being written
- core_rst_o  out  1  holds the FPU core in reset until loading is done
- done_o  out  1  loading complete (sticky until reset)
- frame_err_o  out  1  sticky, set by any bad stop bit

Behaviour:
- Reset: one clock (wb_clk_i), asynchronous active-high reset (wb_rst_i).
- Reset values of outputs:
  - ready_o=0, imem_we_o=0, imem_addr_o=0, imem_wdata_o=0
  - core_rst_o=1, done_o=0, frame_err_o=0
  - Byte counter and address counter = 0; synchronizer flops = 1.
- rx_i path: two-flop synchronizer; all RX logic uses the synchronized value rxs.
- Loader FSM:
  - INIT: one cycle after reset deasserts -> LOAD.
  - LOAD: ready_o=1; bytes accepted.
  - DONE: ready_o=0, core_rst_o=0, done_o=1; rx ignored; left only by reset.
- RX FSM (active only in LOAD):
  - R_IDLE: rxs==0 -> R_START, bit counter cleared.
  - R_START: wait CLKS_PER_BIT/2 cycles (integer divide) and resample.
    - rxs==1: false start -> R_IDLE.
    - Otherwise -> R_DATA.
  - R_DATA: sample every CLKS_PER_BIT cycles; 8 bits, LSB first, into a shift register -> R_STOP.
  - R_STOP: sample after CLKS_PER_BIT cycles.
    - rxs==1: byte_valid pulses for one cycle.
    - rxs==0: frame_err_o set, byte discarded.
    - Either way -> R_IDLE, so the next start bit is detected at the earliest one cycle later.
- Word assembly:
  - Byte k (0..3) goes to word[8k+7:8k].
  - On the 4th valid byte, the word completes on the cycle after that byte_valid.
- Word completion, terminator case (word==END_WORD):
  - No write; byte counter cleared; FSM -> DONE.
- Word completion, any other word:
  - imem_we_o=1 for exactly one cycle.
  - imem_wdata_o = word; imem_addr_o = current address.
  - The address increments the cycle after the strobe.
  - imem_wdata_o and imem_addr_o stay stable while imem_we_o=1 and hold their values afterwards.
- Address full: a write to address 2^ADDR_W-1 transitions to DONE after the strobe; the address does not wrap.
- Frame error: the byte counter is not advanced, so the packing alignment of the partial word is preserved.
- Reset mid-operation: any partial word and in-flight byte are discarded; the design restarts in INIT with address 0.
- Latency: stop-bit sample -> byte_valid 0 cycles (same cycle); 4th byte_valid -> imem_we_o 1 cycle.

Test Plan:
- Normal load:
  - Stimulus: reset, then bytes 13 05 00 00, 93 06 10 00, FF 0F 00 00 at CLKS_PER_BIT=8.
  - Required: writes addr0=0x00000513 and addr1=0x00100693, each with a one-cycle we; then done_o=1, core_rst_o=0, ready_o=0, and no third write.
- Frame error:
  - Stimulus: byte 0xAA sent with stop bit 0, then 13 05 00 00.
  - Required: frame_err_o=1; the bad byte is not stored; addr0=0x00000513.
- Glitch on rx:
  - Stimulus: a 2-cycle low pulse on rx_i while idle (CLKS_PER_BIT=8).
  - Required: no byte_valid, no write, frame_err_o stays 0.
- Address full:
  - Stimulus: ADDR_W=2, five non-terminator words.
  - Required: writes at addr 0..3 only; done_o=1 after the addr-3 write; the fifth word is ignored.
- Reset mid-word:
  - Stimulus: assert wb_rst_i after 2 bytes of a word; release; send 78 56 34 12.
  - Required: addr0=0x12345678; all outputs hold their reset values while wb_rst_i is high.
- Ready handshake:
  - Stimulus: release reset.
  - Required: ready_o rises 2 cycles after wb_rst_i falls and remains 1 until the terminator is processed.

Source files
------------

// File: rtl/uart_imem_loader.sv
// UART instruction-memory loader.
// Receives 8N1 bytes on rx_i, packs them little-endian into 32-bit words and
// writes each word to consecutive instruction-memory addresses.  The FPU core
// is held in reset until a terminator word arrives or the memory is full.
module uart_imem_loader #(
    parameter int          CLKS_PER_BIT = 347,
    parameter int          ADDR_W       = 8,
    parameter logic [31:0] END_WORD     = 32'h0000_0FFF
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              rx_i,
    output logic              ready_o,
    output logic              imem_we_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    output logic [31:0]       imem_wdata_o,
    output logic              core_rst_o,
    output logic              done_o,
    output logic              frame_err_o
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    // Loader states
    localparam logic [1:0] S_INIT = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Receiver states
    localparam logic [1:0] R_IDLE  = 2'd0;
    localparam logic [1:0] R_START = 2'd1;
    localparam logic [1:0] R_DATA  = 2'd2;
    localparam logic [1:0] R_STOP  = 2'd3;

    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic              rx_meta;
    logic              rxs;
    logic [1:0]        state;
    logic [1:0]        rx_state;
    logic [CNT_W-1:0]  clk_cnt;
    logic [2:0]        bit_cnt;
    logic [7:0]        shift;
    logic [1:0]        byte_cnt;
    logic [23:0]       word_lo;
    logic [ADDR_W-1:0] addr_cnt;
    logic              byte_valid;
    logic [31:0]       full_word;

    // A byte is valid in the same cycle its stop bit is sampled high.
    assign byte_valid = (state == S_LOAD) && (rx_state == R_STOP) &&
                        (clk_cnt == BIT_LAST) && rxs;

    // Only meaningful when the fourth byte is the one arriving.
    assign full_word = {shift, word_lo};

    // Two-flop synchronizer for the asynchronous serial line.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx_i;
            rxs     <= rx_meta;
        end
    end

    // Bit-level receiver; held idle whenever the loader is not accepting bytes.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            rx_state    <= R_IDLE;
            clk_cnt     <= '0;
            bit_cnt     <= '0;
            shift       <= '0;
            frame_err_o <= 1'b0;
        end else if (state != S_LOAD) begin
            rx_state <= R_IDLE;
            clk_cnt  <= '0;
        end else begin
            case (rx_state)
                R_IDLE: begin
                    if (!rxs) begin
                        rx_state <= R_START;
                        clk_cnt  <= '0;
                        bit_cnt  <= '0;
                    end
                end
                R_START: begin
                    if (clk_cnt == HALF_LAST) begin
                        clk_cnt  <= '0;
                        rx_state <= rxs ? R_IDLE : R_DATA;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                R_DATA: begin
                    if (clk_cnt == BIT_LAST) begin
                        clk_cnt <= '0;
                        shift   <= {rxs, shift[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7) begin
                            rx_state <= R_STOP;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                R_STOP: begin
                    if (clk_cnt == BIT_LAST) begin
                        clk_cnt  <= '0;
                        rx_state <= R_IDLE;
                        if (!rxs) begin
                            frame_err_o <= 1'b1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                default: rx_state <= R_IDLE;
            endcase
        end
    end

    // Loader sequencing, word packing and instruction-memory writes.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state        <= S_INIT;
            byte_cnt     <= '0;
            word_lo      <= '0;
            addr_cnt     <= '0;
            imem_we_o    <= 1'b0;
            imem_addr_o  <= '0;
            imem_wdata_o <= '0;
        end else begin
            imem_we_o <= 1'b0;
            case (state)
                S_INIT: state <= S_LOAD;
                S_LOAD: begin
                    if (imem_we_o) begin
                        if (addr_cnt == {ADDR_W{1'b1}}) begin
                            state <= S_DONE;
                        end else begin
                            addr_cnt <= addr_cnt + ADDR_ONE;
                        end
                    end
                    if (byte_valid) begin
                        byte_cnt <= byte_cnt + 1'b1;
                        case (byte_cnt)
                            2'd0: word_lo[7:0]   <= shift;
                            2'd1: word_lo[15:8]  <= shift;
                            2'd2: word_lo[23:16] <= shift;
                            default: begin
                                if (full_word == END_WORD) begin
                                    state    <= S_DONE;
                                    byte_cnt <= '0;
                                end else begin
                                    imem_we_o    <= 1'b1;
                                    imem_addr_o  <= addr_cnt;
                                    imem_wdata_o <= full_word;
                                end
                            end
                        endcase
                    end
                end
                default: state <= S_DONE;
            endcase
        end
    end

    // Registered status outputs derived from the loader state.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            ready_o    <= 1'b0;
            done_o     <= 1'b0;
            core_rst_o <= 1'b1;
        end else begin
            ready_o    <= (state == S_LOAD);
            done_o     <= (state == S_DONE);
            core_rst_o <= (state != S_DONE);
        end
    end

endmodule

// File: tb/tb_uart_imem_loader.sv
// Testbench for uart_imem_loader: serial byte stimulus, a byte-stream reference
// model that predicts memory writes, and a monitor that checks each write.
module tb_uart_imem_loader;

    localparam int          CPB   = 8;
    localparam int          AW    = 2;
    localparam logic [31:0] END_W = 32'h0000_0FFF;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rx  = 1'b1;
    logic          ready_o;
    logic          imem_we_o;
    logic [AW-1:0] imem_addr_o;
    logic [31:0]   imem_wdata_o;
    logic          core_rst_o;
    logic          done_o;
    logic          frame_err_o;

    always #5 clk = ~clk;

    uart_imem_loader #(
        .CLKS_PER_BIT(CPB),
        .ADDR_W      (AW),
        .END_WORD    (END_W)
    ) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .rx_i        (rx),
        .ready_o     (ready_o),
        .imem_we_o   (imem_we_o),
        .imem_addr_o (imem_addr_o),
        .imem_wdata_o(imem_wdata_o),
        .core_rst_o  (core_rst_o),
        .done_o      (done_o),
        .frame_err_o (frame_err_o)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    wr_t  exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model state: what the programmer has sent so far
    int          m_addr;
    int          m_cnt;
    logic [31:0] m_word;
    bit          m_done;
    bit          m_ferr;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic model_reset();
        m_addr = 0;
        m_cnt  = 0;
        m_word = '0;
        m_done = 1'b0;
        m_ferr = 1'b0;
    endtask

    // Predict the loader's reaction to one received byte.
    task automatic model_byte(input logic [7:0] b, input bit good);
        wr_t w;
        if (m_done) return;
        if (!good) begin
            m_ferr = 1'b1;
            return;
        end
        m_word[8*m_cnt +: 8] = b;
        m_cnt++;
        if (m_cnt == 4) begin
            m_cnt = 0;
            if (m_word == END_W) begin
                m_done = 1'b1;
            end else begin
                w.addr = m_addr[AW-1:0];
                w.data = m_word;
                exp_q.push_back(w);
                if (m_addr == (1 << AW) - 1) m_done = 1'b1;
                else m_addr++;
            end
        end
    endtask

    task automatic check_status();
        checkOutput("ready_o",     ready_o,     !m_done);
        checkOutput("done_o",      done_o,      m_done);
        checkOutput("core_rst_o",  core_rst_o,  !m_done);
        checkOutput("frame_err_o", frame_err_o, m_ferr);
    endtask

    // Send one 8N1 frame; good=0 drives a low stop bit.
    task automatic applyStimulus(input logic [7:0] b, input bit good);
        model_byte(b, good);
        @(negedge clk) rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = good;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        check_status();
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) applyStimulus(w[8*k +: 8], 1'b1);
    endtask

    task automatic do_reset();
        @(negedge clk) rst = 1'b1;
        rx = 1'b1;
        model_reset();
        @(negedge clk);
        checkOutput("rst_ready",     ready_o,      0);
        checkOutput("rst_we",        imem_we_o,    0);
        checkOutput("rst_addr",      imem_addr_o,  0);
        checkOutput("rst_wdata",     imem_wdata_o, 0);
        checkOutput("rst_core_rst",  core_rst_o,   1);
        checkOutput("rst_done",      done_o,       0);
        checkOutput("rst_frame_err", frame_err_o,  0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("ready_after_1", ready_o, 0);
        @(negedge clk);
        checkOutput("ready_after_2", ready_o, 1);
    endtask

    task automatic check_drained();
        checkOutput("pending_writes", exp_q.size(), 0);
    endtask

    // Monitor: every write strobe is matched against the predicted queue.
    logic          prev_we = 1'b0;
    logic [31:0]   last_data = '0;
    logic [AW-1:0] last_addr = '0;
    always @(negedge clk) begin
        wr_t e;
        if (rst) begin
            prev_we <= 1'b0;
        end else begin
            if (imem_we_o) begin
                checkOutput("we_one_cycle", prev_we, 0);
                if (!prev_we) begin
                    checkOutput("write_expected", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        checkOutput("write_addr", imem_addr_o, e.addr);
                        checkOutput("write_data", imem_wdata_o, e.data);
                    end
                end
            end else if (prev_we) begin
                checkOutput("wdata_hold", imem_wdata_o, last_data);
                checkOutput("addr_hold",  imem_addr_o,  last_addr);
            end
            prev_we   <= imem_we_o;
            last_data <= imem_wdata_o;
            last_addr <= imem_addr_o;
        end
    end

    initial begin
        logic [31:0] w;
        int          nwords;

        // Normal load, then a word sent after the terminator must be ignored
        do_reset();
        send_word(32'h0000_0513);
        send_word(32'h0010_0693);
        send_word(END_W);
        send_word(32'h1111_2222);
        check_drained();

        // Frame error: bad byte is dropped without disturbing alignment
        do_reset();
        applyStimulus(8'hAA, 1'b0);
        send_word(32'h0000_0513);
        send_word(END_W);
        check_drained();

        // Short glitch on an idle line is not a start bit
        do_reset();
        @(negedge clk) rx = 1'b0;
        repeat (2) @(negedge clk);
        rx = 1'b1;
        repeat (5 * CPB) @(negedge clk);
        check_status();
        send_word(32'h0000_0513);
        send_word(END_W);
        check_drained();

        // Address full: only four writes, fifth word ignored
        do_reset();
        for (int i = 0; i < 5; i++) send_word($urandom | 32'h8000_0000);
        check_drained();

        // Reset mid-word discards the partial word and restarts at address 0
        do_reset();
        send_word(32'hCAFE_BABE);
        applyStimulus(8'h11, 1'b1);
        applyStimulus(8'h22, 1'b1);
        check_drained();
        do_reset();
        send_word(32'h1234_5678);
        send_word(END_W);
        check_drained();

        // Randomized loads with occasional framing errors
        for (int it = 0; it < 6; it++) begin
            do_reset();
            nwords = $urandom_range(1, 5);
            for (int n = 0; n < nwords; n++) begin
                w = $urandom;
                for (int k = 0; k < 4; k++)
                    applyStimulus(w[8*k +: 8], $urandom_range(0, 9) != 0);
            end
            if ($urandom_range(0, 1) == 1) send_word(END_W);
            check_drained();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
